// File: rtl/skew_pingpong_buffer.sv
// ---------------------------------------------------------------------------
// skew_pingpong_buffer
//
// Double-buffered tile store that feeds a systolic array. The write side
// fills one DIM x DIM tile row by row while the read side drains the other
// tile as a diagonal wavefront: lane i is delayed by i cycles so that the
// elements arrive at the array edge already skewed.
//
// TRANSPOSE = 0 drains rows along lanes (A-side feed):    lane r -> M[r][t-r]
// TRANSPOSE = 1 drains columns along lanes (B-side feed): lane c -> M[t-c][c]
//
// Elements are BITS-wide two's complement values; the buffer only moves them.
//
// Ports
//   clk        single clock, every state update on its rising edge
//   rst        synchronous active-high reset
//   wr_en      write wr_data into row wr_row of the current write bank
//   wr_row     row index for wr_en
//   wr_data    row elements, element k = column k
//   wr_commit  mark the write bank complete and hand it to the read side
//   wr_ready   write bank is free; writes and commits are accepted
//   rd_start   request a drain of the current read bank
//   rd_busy    drain in progress
//   out_data   skewed lane outputs (registered)
//   out_valid  out_data carries a drain cycle
//   out_last   final drain cycle
//   bank_full  per-bank full flags
// ---------------------------------------------------------------------------
module skew_pingpong_buffer #(
  parameter int BITS      = 8,
  parameter int DIM       = 8,
  parameter int TRANSPOSE = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr_en,
  input  logic [$clog2(DIM)-1:0]         wr_row,
  input  logic signed [DIM-1:0][BITS-1:0] wr_data,
  input  logic                           wr_commit,
  output logic                           wr_ready,
  input  logic                           rd_start,
  output logic                           rd_busy,
  output logic signed [DIM-1:0][BITS-1:0] out_data,
  output logic                           out_valid,
  output logic                           out_last,
  output logic [1:0]                     bank_full
);

  // The drain index t runs 0 .. 2*DIM-2, so it needs log2(2*DIM) bits.
  localparam int TW = $clog2(2 * DIM);
  localparam logic [TW-1:0] LAST_T = TW'(2 * DIM - 2);

  typedef enum logic {
    IDLE,
    DRAIN
  } state_t;

  state_t state;
  state_t next_state;

  // Element storage is left unreset: the row-valid bits decide what a
  // drain may expose, so stale contents are never visible.
  logic [DIM-1:0][BITS-1:0] mem [2][DIM];
  logic [DIM-1:0]           row_valid [2];
  logic                     wr_ptr;
  logic                     rd_ptr;
  logic [TW-1:0]            t_cnt;

  logic                     wr_accept;
  logic                     commit_accept;
  logic                     release_bank;
  logic [TW-1:0]            next_t;
  logic                     next_valid;
  logic                     next_last;
  logic [DIM-1:0][BITS-1:0] next_data;

  assign wr_ready      = !bank_full[wr_ptr];
  assign rd_busy       = (state == DRAIN);
  assign wr_accept     = wr_en && wr_ready;
  assign commit_accept = wr_commit && wr_ready;

  // Drain state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Drain sequencing. The output registers are loaded with the values for
  // the upcoming cycle, so a start accepted at one edge shows t = 0 right
  // after it, and the edge that ends the t = LAST_T cycle releases the bank.
  always_comb begin
    next_state   = state;
    release_bank = 1'b0;
    next_t       = '0;
    next_valid   = 1'b0;
    next_last    = 1'b0;
    case (state)
      IDLE: begin
        if (rd_start && bank_full[rd_ptr]) begin
          next_state = DRAIN;
          next_valid = 1'b1;
        end
      end
      DRAIN: begin
        if (t_cnt == LAST_T) begin
          next_state   = IDLE;
          release_bank = 1'b1;
        end else begin
          next_t     = t_cnt + TW'(1);
          next_valid = 1'b1;
          next_last  = (next_t == LAST_T);
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Wavefront selection for the upcoming cycle: each lane sits on the
  // anti-diagonal (next_t - lane); outside the tile, or on a row that was
  // never written, the lane carries zero.
  always_comb begin
    next_data = '0;
    if (next_valid) begin
      for (int lane = 0; lane < DIM; lane++) begin
        if ((int'(next_t) - lane >= 0) && (int'(next_t) - lane < DIM)) begin
          if (TRANSPOSE == 0) begin
            if (row_valid[rd_ptr][lane])
              next_data[lane] = mem[rd_ptr][lane][int'(next_t) - lane];
          end else begin
            if (row_valid[rd_ptr][int'(next_t) - lane])
              next_data[lane] = mem[rd_ptr][int'(next_t) - lane][lane];
          end
        end
      end
    end
  end

  // Row storage. Writes are gated by reset so a write presented together
  // with reset never lands.
  always_ff @(posedge clk) begin
    if (!rst && wr_accept) begin
      mem[wr_ptr][wr_row] <= wr_data;
    end
  end

  // Bank bookkeeping and registered outputs. A commit always targets the
  // write bank and a release always targets the read bank, which is full;
  // since a commit needs a free write bank the two never name the same bank
  // and both take effect in the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      bank_full    <= '0;
      row_valid[0] <= '0;
      row_valid[1] <= '0;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      t_cnt        <= '0;
      out_data     <= '0;
      out_valid    <= 1'b0;
      out_last     <= 1'b0;
    end else begin
      t_cnt     <= next_t;
      out_data  <= next_data;
      out_valid <= next_valid;
      out_last  <= next_last;
      if (wr_accept) begin
        row_valid[wr_ptr][wr_row] <= 1'b1;
      end
      if (commit_accept) begin
        bank_full[wr_ptr] <= 1'b1;
        wr_ptr            <= ~wr_ptr;
      end
      if (release_bank) begin
        bank_full[rd_ptr] <= 1'b0;
        row_valid[rd_ptr] <= '0;
        rd_ptr            <= ~rd_ptr;
      end
    end
  end

endmodule

// File: tb/tb_skew_pingpong_buffer.sv
// ---------------------------------------------------------------------------
// tb_skew_pingpong_buffer
//
// Drives one stimulus stream into two buffers (row feed and column feed).
// A behavioural model tracks the banks; whenever it sees a drain accepted it
// pushes the whole expected wavefront into queues that the output monitor
// pops and compares.
// ---------------------------------------------------------------------------
module tb_skew_pingpong_buffer;

  localparam int BITS = 8;
  localparam int DIM  = 4;
  localparam int NOUT = 2 * DIM - 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [1:0]  wr_row;
  logic [31:0] wr_data;
  logic        wr_commit;
  logic        rd_start;

  logic        wr_ready0, wr_ready1;
  logic        rd_busy0, rd_busy1;
  logic [31:0] out_data0, out_data1;
  logic        out_valid0, out_valid1;
  logic        out_last0, out_last1;
  logic [1:0]  bank_full0, bank_full1;

  int cmp_count = 0;
  int err_count = 0;
  bit mon_on = 1'b0;

  // Model state
  logic [7:0]  m_mem [2][4][4];
  logic [3:0]  m_valid [2];
  logic [1:0]  m_full;
  logic        m_wptr;
  logic        m_rptr;
  int          m_left;
  bit          m_wr_ok, m_idle, m_rel;

  logic [31:0] exp0 [$];
  logic [31:0] exp1 [$];
  bit          exp_last [$];

  always #5 clk = ~clk;

  skew_pingpong_buffer #(.BITS(BITS), .DIM(DIM), .TRANSPOSE(0)) dut0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_row(wr_row), .wr_data(wr_data),
    .wr_commit(wr_commit), .wr_ready(wr_ready0), .rd_start(rd_start),
    .rd_busy(rd_busy0), .out_data(out_data0), .out_valid(out_valid0),
    .out_last(out_last0), .bank_full(bank_full0)
  );

  skew_pingpong_buffer #(.BITS(BITS), .DIM(DIM), .TRANSPOSE(1)) dut1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_row(wr_row), .wr_data(wr_data),
    .wr_commit(wr_commit), .wr_ready(wr_ready1), .rd_start(rd_start),
    .rd_busy(rd_busy1), .out_data(out_data1), .out_valid(out_valid1),
    .out_last(out_last1), .bank_full(bank_full1)
  );

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    cmp_count++;
    if (obs !== exp) begin
      err_count++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock of stimulus: inputs held across the next rising edge.
  task automatic applyStimulus(input bit r, input bit we, input int row,
                               input logic [31:0] data, input bit commit, input bit start);
    rst       = r;
    wr_en     = we;
    wr_row    = 2'(row);
    wr_data   = data;
    wr_commit = commit;
    rd_start  = start;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    wr_en     = 1'b0;
    wr_row    = '0;
    wr_data   = '0;
    wr_commit = 1'b0;
    rd_start  = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 32'h0, 0, 0);
  endtask

  function automatic logic [31:0] tileRow(input int base, input int r);
    logic [31:0] d;
    d = '0;
    for (int k = 0; k < DIM; k++) d[k*8 +: 8] = 8'(base + 16 * r + k);
    return d;
  endfunction

  // Write the rows selected by mask; commit together with the last one.
  task automatic loadTile(input int base, input logic [3:0] mask);
    int last_row;
    last_row = 0;
    for (int r = 0; r < DIM; r++) if (mask[r]) last_row = r;
    for (int r = 0; r < DIM; r++)
      if (mask[r]) applyStimulus(0, 1, r, tileRow(base, r), (r == last_row), 0);
  endtask

  task automatic waitDrained();
    int budget;
    budget = 0;
    while ((m_left != 0 || exp0.size() != 0) && budget < 40) begin
      idleCycles(1);
      budget++;
    end
    if (budget >= 40) checkOutput("drain_timeout", 64'd1, 64'd0);
    checkOutput("queue_empty", 64'(exp0.size()), 64'd0);
  endtask

  // Behavioural model, evaluated on the same edges as the designs.
  always @(posedge clk) begin
    if (rst) begin
      m_full     = '0;
      m_valid[0] = '0;
      m_valid[1] = '0;
      m_wptr     = 1'b0;
      m_rptr     = 1'b0;
      m_left     = 0;
      exp0.delete();
      exp1.delete();
      exp_last.delete();
    end else begin
      m_wr_ok = !m_full[m_wptr];
      m_idle  = (m_left == 0);
      m_rel   = (m_left == 1);
      if (m_left > 0) m_left--;
      if (m_idle && rd_start && m_full[m_rptr]) begin
        for (int t = 0; t < NOUT; t++) begin
          logic [31:0] v0, v1;
          v0 = '0;
          v1 = '0;
          for (int lane = 0; lane < DIM; lane++) begin
            if (t - lane >= 0 && t - lane < DIM) begin
              if (m_valid[m_rptr][lane])    v0[lane*8 +: 8] = m_mem[m_rptr][lane][t - lane];
              if (m_valid[m_rptr][t - lane]) v1[lane*8 +: 8] = m_mem[m_rptr][t - lane][lane];
            end
          end
          exp0.push_back(v0);
          exp1.push_back(v1);
          exp_last.push_back(t == NOUT - 1);
        end
        m_left = NOUT;
      end
      if (wr_en && m_wr_ok) begin
        for (int k = 0; k < DIM; k++) m_mem[m_wptr][wr_row][k] = wr_data[k*8 +: 8];
        m_valid[m_wptr][wr_row] = 1'b1;
      end
      if (wr_commit && m_wr_ok) begin
        m_full[m_wptr] = 1'b1;
        m_wptr         = ~m_wptr;
      end
      if (m_rel) begin
        m_full[m_rptr]  = 1'b0;
        m_valid[m_rptr] = '0;
        m_rptr          = ~m_rptr;
      end
    end
  end

  // Output monitor, sampling mid-cycle.
  always @(negedge clk) begin
    if (mon_on) begin
      checkOutput("out_valid0", 64'(out_valid0), 64'(m_left > 0));
      checkOutput("out_valid1", 64'(out_valid1), 64'(m_left > 0));
      checkOutput("rd_busy",    64'(rd_busy0),   64'(m_left > 0));
      checkOutput("bank_full",  64'(bank_full0), 64'(m_full));
      checkOutput("bank_full1", 64'(bank_full1), 64'(m_full));
      checkOutput("wr_ready",   64'(wr_ready0),  64'(!m_full[m_wptr]));
      if (out_valid0) begin
        if (exp0.size() == 0) begin
          checkOutput("unexpected_out", 64'd1, 64'd0);
        end else begin
          checkOutput("row_feed_data", 64'(out_data0), 64'(exp0.pop_front()));
          checkOutput("col_feed_data", 64'(out_data1), 64'(exp1.pop_front()));
          checkOutput("out_last",      64'(out_last0), 64'(exp_last.pop_front()));
        end
      end else begin
        checkOutput("idle_zero0", 64'(out_data0), 64'd0);
        checkOutput("idle_zero1", 64'(out_data1), 64'd0);
        checkOutput("idle_last",  64'(out_last0), 64'd0);
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    wr_en     = 1'b0;
    wr_row    = '0;
    wr_data   = '0;
    wr_commit = 1'b0;
    rd_start  = 1'b0;
    applyStimulus(1, 0, 0, 32'h0, 0, 0);
    applyStimulus(1, 0, 0, 32'h0, 0, 0);
    mon_on = 1'b1;
    checkOutput("reset_wr_ready",  64'(wr_ready0),  64'd1);
    checkOutput("reset_bank_full", 64'(bank_full0), 64'd0);
    checkOutput("reset_out_valid", 64'(out_valid0), 64'd0);
    checkOutput("reset_rd_busy",   64'(rd_busy0),   64'd0);

    $display("[TB] full tile, commit with last row");
    loadTile(0, 4'b1111);
    applyStimulus(0, 0, 0, 32'h0, 0, 1);
    waitDrained();

    $display("[TB] sparse tile, rows 0 and 2");
    loadTile(8'h40, 4'b0101);
    applyStimulus(0, 0, 0, 32'h0, 0, 1);
    waitDrained();

    $display("[TB] both banks full");
    loadTile(8'h05, 4'b1111);
    loadTile(8'h08, 4'b1111);
    checkOutput("both_full_ready", 64'(wr_ready0), 64'd0);
    applyStimulus(0, 1, 1, 32'h7f7f7f7f, 0, 0);
    applyStimulus(0, 0, 0, 32'h0, 0, 1);
    waitDrained();
    checkOutput("ready_after_release", 64'(wr_ready0), 64'd1);
    applyStimulus(0, 0, 0, 32'h0, 0, 1);
    waitDrained();

    $display("[TB] load during drain, commit on release edge");
    loadTile(8'h10, 4'b1111);
    applyStimulus(0, 0, 0, 32'h0, 0, 1);
    for (int r = 0; r < DIM; r++) applyStimulus(0, 1, r, tileRow(8'h20, r), 0, 0);
    idleCycles(2);
    applyStimulus(0, 0, 0, 32'h0, 1, 1);
    applyStimulus(0, 0, 0, 32'h0, 0, 1);
    waitDrained();

    $display("[TB] reset mid-drain");
    loadTile(8'h30, 4'b1111);
    applyStimulus(0, 0, 0, 32'h0, 0, 1);
    idleCycles(3);
    applyStimulus(1, 1, 0, 32'h11111111, 1, 1);
    checkOutput("abort_out_valid", 64'(out_valid0), 64'd0);
    checkOutput("abort_bank_full", 64'(bank_full0), 64'd0);
    checkOutput("abort_wr_ready",  64'(wr_ready0),  64'd1);
    applyStimulus(0, 0, 0, 32'h0, 0, 1);
    idleCycles(4);
    checkOutput("abort_no_drain", 64'(out_valid0), 64'd0);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) != 0),
                    int'($urandom_range(0, 3)), $urandom(),
                    ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0));
    end
    waitDrained();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
    $finish;
  end

endmodule
